// File: rtl/rv32i_types.sv
// Shared types for the L1-to-L2 path: cache line, arbiter FSM state, grantee id
// and the captured downstream command.
package rv32i_types;

  localparam int unsigned CACHE_LINE_W = 256;
  localparam int unsigned ADDR_W       = 32;

  typedef logic [CACHE_LINE_W-1:0] rv32i_cache_line;
  typedef logic [ADDR_W-1:0]       rv32i_word;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_REQ_I = 1'b0,
    ARB_REQ_D = 1'b1
  } arb_req_t;

  // Request captured at grant time and replayed downstream until resp.
  typedef struct packed {
    rv32i_word       addr;
    rv32i_cache_line wdata;
    logic            read;
    logic            write;
  } arb_cmd_t;

endpackage

// File: rtl/arbiter_grant.sv
// Combinational tie-break between I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN: ties alternate against last_grant; otherwise D wins ties.
module arbiter_grant
  import rv32i_types::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  arb_req_t last_grant_i,
  output arb_req_t grant_c
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_c = ARB_REQ_D;
    if (i_req_i && !d_req_i) begin
      grant_c = ARB_REQ_I;
    end else if (i_req_i && d_req_i) begin
      grant_c = (last_grant_i == ARB_REQ_D) ? ARB_REQ_I : ARB_REQ_D;
    end
  end
`else
  // History is still tracked by the parent but has no influence here.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_i == ARB_REQ_D);

  always_comb begin
    grant_c = ARB_REQ_D;
    if (i_req_i && !d_req_i) begin
      grant_c = ARB_REQ_I;
    end
  end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem/L2 port between the L1 I-cache and D-cache, one full line
// transaction at a time. Tie policy selected by ARB_ROUND_ROBIN_EN (see arbiter_grant).
module cache_arbiter
  import rv32i_types::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       i_pmem_address,
  input  logic                    i_pmem_read,
  output logic [CACHE_LINE_W-1:0] i_pmem_rdata,
  output logic                    i_pmem_resp,
  input  logic [ADDR_W-1:0]       d_pmem_address,
  input  logic [CACHE_LINE_W-1:0] d_pmem_wdata,
  input  logic                    d_pmem_read,
  input  logic                    d_pmem_write,
  output logic [CACHE_LINE_W-1:0] d_pmem_rdata,
  output logic                    d_pmem_resp,
  output logic [ADDR_W-1:0]       pmem_address,
  output logic [CACHE_LINE_W-1:0] pmem_wdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic [CACHE_LINE_W-1:0] pmem_rdata,
  input  logic                    pmem_resp
);

  arb_state_t state_q, state_d;
  arb_cmd_t   cmd_q, cmd_d;
  arb_req_t   last_grant_q, last_grant_d;
  arb_req_t   grant_c;
  logic       i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  arbiter_grant u_grant (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .grant_c      (grant_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      last_grant_q <= ARB_REQ_D;
    end else begin
      cmd_q        <= cmd_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant and capture in IDLE; drop the downstream strobe on resp; DONE is a dead cycle.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = grant_c;
          if (grant_c == ARB_REQ_I) begin
            state_d     = ARB_SERVE_I;
            cmd_d.addr  = i_pmem_address;
            cmd_d.wdata = '0;
            cmd_d.read  = 1'b1;
            cmd_d.write = 1'b0;
          end else begin
            state_d     = ARB_SERVE_D;
            cmd_d.addr  = d_pmem_address;
            cmd_d.wdata = d_pmem_wdata;
            cmd_d.read  = ~d_pmem_write;
            cmd_d.write = d_pmem_write;
          end
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d     = ARB_DONE;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign pmem_address = cmd_q.addr;
  assign pmem_wdata   = cmd_q.wdata;
  assign pmem_read    = cmd_q.read;
  assign pmem_write   = cmd_q.write;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = pmem_resp && (state_q == ARB_SERVE_I);
  assign d_pmem_resp  = pmem_resp && (state_q == ARB_SERVE_D);

  // The D-cache must never read and write at once; the write is what gets served.
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by random
// I/D cache and memory traffic, all checked against a timestamp-based reference.
module tb_cache_arbiter;
  import rv32i_types::*;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_pmem_address, d_pmem_address, pmem_address;
  logic [255:0] d_pmem_wdata, i_pmem_rdata, d_pmem_rdata, pmem_wdata, pmem_rdata;
  logic         i_pmem_read, i_pmem_resp, d_pmem_read, d_pmem_write, d_pmem_resp;
  logic         pmem_read, pmem_write, pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  // Staged inputs, applied together at the next falling edge.
  logic         nx_rst_n, nx_i_read, nx_d_read, nx_d_write, nx_presp;
  logic [31:0]  nx_i_addr, nx_d_addr;
  logic [255:0] nx_d_wdata, nx_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: one transaction in flight; after its resp at cycle M the next grant
  // may be decided no earlier than cycle M+2.
  int           cyc      = 0;
  int           ready_at = 0;
  bit           m_act    = 1'b0;
  bit           m_own_d  = 1'b0;
  bit           m_last_d = 1'b1;
  bit           m_wr     = 1'b0;
  logic [31:0]  m_addr   = '0;
  logic [255:0] m_wdata  = '0;

  int           i_resp_cnt, d_resp_cnt, rd_seen;
  bit           prev_act = 1'b0;
  logic [31:0]  g_log[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit i_rq, d_rq, cur_act;
    @(negedge clk);
    rst_n          = nx_rst_n;
    i_pmem_read    = nx_i_read;
    i_pmem_address = nx_i_addr;
    d_pmem_read    = nx_d_read;
    d_pmem_write   = nx_d_write;
    d_pmem_address = nx_d_addr;
    d_pmem_wdata   = nx_d_wdata;
    pmem_resp      = nx_presp;
    pmem_rdata     = nx_rdata;
    #1;
    cyc++;
    if (!rst_n) begin
      m_act = 1'b0; m_last_d = 1'b1; ready_at = 0;
    end
    check("pmem_read", pmem_read, m_act && !m_wr);
    check("pmem_write", pmem_write, m_act && m_wr);
    if (m_act) check("pmem_address", pmem_address, m_addr);
    if (m_act && m_wr) check("pmem_wdata", pmem_wdata, m_wdata);
    check("i_resp", i_pmem_resp, rst_n && m_act && pmem_resp && !m_own_d);
    check("d_resp", d_pmem_resp, rst_n && m_act && pmem_resp && m_own_d);
    check("i_rdata", i_pmem_rdata, pmem_rdata);
    check("d_rdata", d_pmem_rdata, pmem_rdata);

    cur_act = pmem_read || pmem_write;
    if (i_pmem_resp) i_resp_cnt++;
    if (d_pmem_resp) d_resp_cnt++;
    if (pmem_read) rd_seen++;
    if (rst_n && !prev_act && cur_act) g_log.push_back(pmem_address);
    prev_act = cur_act;

    if (rst_n) begin
      i_rq = i_pmem_read;
      d_rq = d_pmem_read || d_pmem_write;
      if (m_act) begin
        if (pmem_resp) begin
          m_act    = 1'b0;
          ready_at = cyc + 2;
        end
      end else if (cyc >= ready_at && (i_rq || d_rq)) begin
        m_act    = 1'b1;
        m_own_d  = (i_rq && d_rq) ? (RR ? !m_last_d : 1'b1) : d_rq;
        m_last_d = m_own_d;
        if (m_own_d) begin
          m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_wr = d_pmem_write;
        end else begin
          m_addr = i_pmem_address; m_wr = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_act();
    int n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      step();
      n++;
    end
    check("wait_grant", pmem_read || pmem_write, 1'b1);
  endtask

  initial begin
    bit          i_pend = 0, d_pend = 0, i_linger = 0, d_linger = 0, d_wr = 0;
    int          mem_wait = 0;
    logic [31:0] exp_a;

    nx_rst_n = 1'b0; nx_i_read = 0; nx_d_read = 0; nx_d_write = 0; nx_presp = 0;
    nx_i_addr = '0; nx_d_addr = '0; nx_d_wdata = '0; nx_rdata = '0;
    step(); step();
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, 256'h0);
    check("rst_i_resp", i_pmem_resp, 1'b0);
    check("rst_d_resp", d_pmem_resp, 1'b0);
    nx_rst_n = 1'b1;
    step();

    // I-cache read of 0x1000, memory answers five cycles after the request
    i_resp_cnt = 0; d_resp_cnt = 0;
    nx_i_read = 1; nx_i_addr = 32'h0000_1000;
    step();
    check("t1_read_cycle_n", pmem_read, 1'b0);
    step();
    check("t1_read_cycle_n1", pmem_read, 1'b1);
    check("t1_address", pmem_address, 32'h0000_1000);
    repeat (3) step();
    nx_presp = 1; step();
    check("t1_i_resp", i_pmem_resp, 1'b1);
    nx_presp = 0; nx_i_read = 0;
    repeat (3) step();
    check("t1_i_pulses", i_resp_cnt, 1);
    check("t1_d_pulses", d_resp_cnt, 0);

    // D-cache writeback of 0x2040 with 0xA5 bytes
    i_resp_cnt = 0; d_resp_cnt = 0; rd_seen = 0;
    nx_d_write = 1; nx_d_addr = 32'h0000_2040; nx_d_wdata = {32{8'hA5}};
    step(); step();
    check("t2_write", pmem_write, 1'b1);
    check("t2_wdata", pmem_wdata, {32{8'hA5}});
    step();
    nx_presp = 1; step();
    check("t2_d_resp", d_pmem_resp, 1'b1);
    nx_presp = 0; nx_d_write = 0;
    repeat (3) step();
    check("t2_d_pulses", d_resp_cnt, 1);
    check("t2_i_pulses", i_resp_cnt, 0);
    check("t2_no_read", rd_seen, 0);

    // Both caches hold reads across four transactions
    g_log.delete();
    nx_i_read = 1; nx_i_addr = 32'h0000_3000;
    nx_d_read = 1; nx_d_addr = 32'h0000_4000;
    for (int t = 0; t < 4; t++) begin
      wait_act();
      step();
      nx_presp = 1; step();
      nx_presp = 0; step();
    end
    nx_i_read = 0; nx_d_read = 0;
    repeat (3) step();
    check("t3_grant_count", g_log.size(), 4);
    for (int t = 0; t < 4; t++) begin
      exp_a = (RR && (t % 2 == 0)) ? 32'h0000_3000 : 32'h0000_4000;
      check("t3_grant_order", (g_log.size() > t) ? g_log[t] : 32'hFFFF_FFFF, exp_a);
    end

    // Requester lingers through the DONE cycle, then drops
    g_log.delete(); i_resp_cnt = 0;
    nx_i_read = 1; nx_i_addr = 32'h0000_5000;
    wait_act();
    step();
    nx_presp = 1; step();
    nx_presp = 0; step();
    nx_i_read = 0;
    repeat (4) step();
    check("t4_single_grant", g_log.size(), 1);
    check("t4_single_resp", i_resp_cnt, 1);

    // Reset during SERVE_D abandons the write with no response
    d_resp_cnt = 0;
    nx_d_write = 1; nx_d_addr = 32'h0000_6000; nx_d_wdata = {8{32'hDEAD_BEEF}};
    wait_act();
    step();
    @(posedge clk); #2;
    rst_n = 1'b0; nx_rst_n = 1'b0;
    #1;
    check("t5_write_dropped", pmem_write, 1'b0);
    nx_d_write = 0; nx_presp = 1;
    step(); step();
    nx_rst_n = 1; nx_presp = 0;
    step();
    check("t5_no_d_resp", d_resp_cnt, 0);
    nx_i_read = 1; nx_i_addr = 32'h0000_7000;
    step(); step();
    check("t5_idle_after_reset", pmem_read, 1'b1);
    nx_presp = 1; step();
    nx_presp = 0; nx_i_read = 0;
    repeat (3) step();

    // Stray responses while idle are not forwarded
    i_resp_cnt = 0; d_resp_cnt = 0;
    nx_presp = 1; step(); step();
    nx_presp = 0; step();
    check("t6_no_i_resp", i_resp_cnt, 0);
    check("t6_no_d_resp", d_resp_cnt, 0);

    // Random traffic from both caches against a variable-latency memory
    for (int c = 0; c < 3000; c++) begin
      nx_rst_n = !(c == 1500 || c == 1501);
      if (i_pmem_resp) begin i_pend = 0; i_linger = ($urandom_range(0, 1) == 1); end
      else i_linger = 0;
      if (d_pmem_resp) begin d_pend = 0; d_linger = ($urandom_range(0, 1) == 1); end
      else d_linger = 0;

      if (!i_pend && !i_linger && $urandom_range(0, 2) == 0) begin
        i_pend = 1; nx_i_addr = $urandom() & 32'hFFFF_FFE0;
      end else if (i_pend && $urandom_range(0, 7) == 0) begin
        nx_i_addr = $urandom() & 32'hFFFF_FFE0;
      end
      if (!d_pend && !d_linger && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wr = ($urandom_range(0, 1) == 1);
        nx_d_addr = $urandom() & 32'hFFFF_FFE0;
        nx_d_wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
      end else if (d_pend && $urandom_range(0, 7) == 0) begin
        nx_d_addr = $urandom() & 32'hFFFF_FFE0;
      end
      nx_i_read  = i_pend || i_linger;
      nx_d_read  = (d_pend || d_linger) && !d_wr;
      nx_d_write = (d_pend || d_linger) && d_wr;

      if ((pmem_read || pmem_write) && !nx_presp) begin
        if (mem_wait == 0) begin
          nx_presp = 1; mem_wait = $urandom_range(0, 5);
        end else begin
          mem_wait--; nx_presp = 0;
        end
      end else begin
        nx_presp = !(pmem_read || pmem_write) && ($urandom_range(0, 15) == 0);
      end
      nx_rdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
